pipelined_cla: RTL
==================

# pipelined_cla

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. The operand width is split into `Stages` equal segments; each segment is added in its own pipeline stage using `Block`-bit lookahead groups, and the carry is registered between stages. The block is the next-generation datapath adder for wide add/sub paths that need a higher clock rate than a single combinational lookahead adder allows. It also produces status flags (carry, signed overflow, zero) alongside the sum.

## Interface
- `Width`, 16: operand and sum width in bits.
- `Block`, 4: lookahead group size inside a segment. Generate/propagate terms and the group carry chain are formed per group.
- `Stages`, 2: pipeline depth, ≥1. Constraint: `Width % (Stages*Block) == 0`. Segment width `Seg = Width/Stages`.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operand beat valid.
- `in_ready` output, 1: block accepts a beat this cycle.
- `a` input, `Width`: operand A, unsigned or two's-complement.
- `b` input, `Width`: operand B.
- `c_in` input, 1: carry in; used only when `sub=0`.
- `sub` input, 1: 0 → A+B+c_in; 1 → A−B, computed as A+~B+1.
- `out_valid` output, 1: result beat valid.
- `out_ready` input, 1: downstream accepts the result.
- `sum` output, `Width`: result, modulo 2^Width.
- `c_out` output, 1: carry out of MSB. In subtract mode, 1 means no borrow.
- `ovf` output, 1: signed overflow, carry into MSB XOR carry out of MSB.
- `zero` output, 1: `sum == 0`.

## Operation
- Input mapping:
  - `b_eff = sub ? ~b : b`
  - `cin_eff = sub ? 1 : c_in`
- Per bit: G = a & b_eff, P = a ^ b_eff.
- Per group: the group carry chain is C[k+1] = G[k] | (P[k] & C[k]). The group carry-out feeds the next group within the same stage.
- Stage s (0..Stages−1):
  - Adds segment bits [s·Seg +: Seg] using the carry registered from stage s−1; stage 0 uses `cin_eff`.
  - Registers its sum slice, its carry-out, and all not-yet-consumed operand bits for later segments. Operand bits are skewed forward and finished sum slices are carried along, so the output is deskewed.
  - The last stage also registers carry-into-MSB, to derive `ovf`.
- `zero` is the NOR of the full registered sum, computed from the final registered value.
- Each stage holds a valid bit. Global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - When `adv`, every stage loads from its predecessor. Stage 0 loads `in_valid && in_ready`.
  - When `!adv`, all stages hold.
- Bubbles are not collapsed: a stalled pipeline with empty middle stages still stalls.
- No combinational path from `in_valid`/`a`/`b` to any output. The only combinational output path is `out_ready` → `in_ready`.
- Reset (asynchronous, `rst_n` low): all valid bits clear and all data registers go to 0. So `out_valid=0`, `sum=0`, `c_out=0`, `ovf=0`, `zero=0` (forced 0 while `!out_valid`), and `in_ready=1`. In-flight beats are discarded, not completed.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+`Stages` (Stages=2: accepted cycle 0, output valid cycle 2).
- Throughput: one beat per cycle while `out_ready=1`.
- Hold under stall: while `out_valid && !out_ready`, `sum`/`c_out`/`ovf`/`zero` stay stable and `in_ready=0`.
- Simultaneous output handshake and input acceptance in the same cycle is allowed (full rate).
- `sub` and `c_in` are sampled with `a`/`b` and travel with their beat, so mixed-mode back-to-back beats are legal.
- Stages=1: single registered adder; latency 1.
- Reset deasserted mid-stream: the first accepted beat after reset is the first beat out.

## Test plan
- Reset then add (Width=16, Stages=2): a=0x1234, b=0x4321, c_in=1, sub=0 → 2 cycles later sum=0x5556, c_out=0, ovf=0, zero=0.
- Wrap and zero: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0, zero=1. Cross-segment carry propagates through the stage register.
- Subtract and overflow:
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, c_out=1, ovf=1.
  - a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, c_out=0 (borrow), ovf=0.
- Backpressure: stream 6 random beats with `out_ready` toggling 1,0,0,1,… → no beat lost or duplicated, outputs stable during stall, `in_ready` low exactly when `out_valid && !out_ready`. Compare against a reference model of A±B.
- Async reset mid-flight: assert `rst_n=0` with 2 beats in the pipe → `out_valid` drops immediately, all outputs 0; after release no stale beat emerges.
- Parameter sweep: (Width,Block,Stages) = (8,4,1), (32,4,4), (64,8,2), 1000 random mixed add/sub beats each → all results match the reference model; latency equals `Stages`.

Source files
------------

// File: rtl/pipelined_cla.sv
// Pipelined carry-lookahead adder/subtractor. Each stage adds one Seg-wide slice
// with Block-bit lookahead groups; the inter-slice carry is registered.
module pipelined_cla #(
  parameter int Width  = 16,
  parameter int Block  = 4,
  parameter int Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int Seg    = Width / Stages;
  localparam int Groups = Seg / Block;

  // Returns {carry_out, sum} for one slice; group carry-outs come from group G/P.
  function automatic logic [Seg:0] cla_seg(input logic [Seg-1:0] x,
                                           input logic [Seg-1:0] y,
                                           input logic           ci);
    logic [Seg-1:0] g, p;
    logic [Seg:0]   c;
    logic           gg, gp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int j = 0; j < Groups; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int k = 0; k < Block; k++) begin
        c[j*Block+k+1] = g[j*Block+k] | (p[j*Block+k] & c[j*Block+k]);
        gg             = g[j*Block+k] | (p[j*Block+k] & gg);
        gp             = gp & p[j*Block+k];
      end
      c[(j+1)*Block] = gg | (gp & c[j*Block]);
    end
    return {c[Seg], p ^ c[Seg-1:0]};
  endfunction

  logic adv;
  logic cmsb_p;

  // Whole pipe advances together; bubbles are not collapsed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < Stages; s++) begin : g_stage
    localparam int Rs = Width - s * Seg;

    logic [Rs-1:0]          a_src, b_src;
    logic                   c_src, vld_src;
    logic [Seg:0]           res;
    logic [(s+1)*Seg-1:0]   sum_nxt, sum_p;
    logic                   c_p, vld_p;

    if (s == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = sub ? ~b : b;
      assign c_src   = sub | c_in;
      assign vld_src = in_valid;
      assign sum_nxt = res[Seg-1:0];
    end else begin : g_body
      assign a_src   = g_stage[s-1].g_fwd.a_p;
      assign b_src   = g_stage[s-1].g_fwd.b_p;
      assign c_src   = g_stage[s-1].c_p;
      assign vld_src = g_stage[s-1].vld_p;
      assign sum_nxt = {res[Seg-1:0], g_stage[s-1].sum_p};
    end

    assign res = cla_seg(a_src[Seg-1:0], b_src[Seg-1:0], c_src);

    // Stage boundary: finished low slices, slice carry and valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        c_p   <= 1'b0;
        sum_p <= '0;
      end else if (adv) begin
        vld_p <= vld_src;
        c_p   <= res[Seg];
        sum_p <= sum_nxt;
      end
    end

    if (s < Stages - 1) begin : g_fwd
      logic [Rs-Seg-1:0] a_p, b_p;
      // Stage boundary: operand bits still waiting for later slices
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (adv) begin
          a_p <= a_src[Rs-1:Seg];
          b_p <= b_src[Rs-1:Seg];
        end
      end
    end else begin : g_tail
      // Stage boundary: carry into the MSB, recovered from the MSB sum bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_p <= 1'b0;
        end else if (adv) begin
          cmsb_p <= res[Seg-1] ^ a_src[Seg-1] ^ b_src[Seg-1];
        end
      end
    end
  end

  assign out_valid = g_stage[Stages-1].vld_p;
  assign sum       = g_stage[Stages-1].sum_p;
  assign c_out     = g_stage[Stages-1].c_p;
  assign ovf       = cmsb_p ^ c_out;
  assign zero      = out_valid & ~|sum;

endmodule
